// File: rtl/vga_draw_arbiter_pkg.sv
// rtl/vga_draw_arbiter_pkg.sv - shared types and helpers for the draw-source arbiter
//
// Purpose: state encoding, mode encoding and a width helper used by the
//          arbiter, its interface and the round-robin picker.
// Ports:   none (package).
package vga_draw_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWNED = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam logic MODE_FORCED = 1'b0;
    localparam logic MODE_ARB    = 1'b1;

    // Ceiling log2, never less than 1 so a 2-source build still gets a select bit.
    function automatic int clog2(input int n);
        int r;
        r = 1;
        while ((1 << r) < n) r = r + 1;
        return r;
    endfunction

endpackage

// File: rtl/vga_draw_arbiter_if.sv
// rtl/vga_draw_arbiter_if.sv - source-side and adapter-side bundle of the draw arbiter
//
// Purpose: groups mode/select, the packed per-source drawing buses and the
//          merged vga_adapter outputs.
// Ports:   master = the game side (drives sources, mode, select);
//          slave  = the arbiter (drives grant, x/y/colour/plot, owner status).
interface vga_draw_arbiter_if #(
    parameter int N_SRC = 8,
    parameter int X_W   = 9,
    parameter int Y_W   = 8,
    parameter int C_W   = 3
);
    localparam int SEL_W = vga_draw_pkg::clog2(N_SRC);

    logic                 mode;
    logic [SEL_W-1:0]     sel_in;
    logic [N_SRC-1:0]     src_req;
    logic [N_SRC*X_W-1:0] src_x;
    logic [N_SRC*Y_W-1:0] src_y;
    logic [N_SRC*C_W-1:0] src_color;
    logic [N_SRC-1:0]     src_plot;
    logic [N_SRC-1:0]     src_grant;
    logic [X_W-1:0]       x_out;
    logic [Y_W-1:0]       y_out;
    logic [C_W-1:0]       color_out;
    logic                 plot_out;
    logic [SEL_W-1:0]     owner;
    logic                 owner_valid;
    logic                 switch_pulse;

    modport master (
        output mode, sel_in, src_req, src_x, src_y, src_color, src_plot,
        input  src_grant, x_out, y_out, color_out, plot_out, owner, owner_valid, switch_pulse
    );

    modport slave (
        input  mode, sel_in, src_req, src_x, src_y, src_color, src_plot,
        output src_grant, x_out, y_out, color_out, plot_out, owner, owner_valid, switch_pulse
    );

endinterface

// File: rtl/vga_draw_arbiter_rr_pick.sv
// rtl/vga_draw_arbiter_rr_pick.sv - combinational round-robin picker
//
// Purpose: returns the first set request searching upward from pointer+1
//          with wrap-around.
// Ports:   i_req (request vector), i_ptr (last winner),
//          o_idx (picked index), o_any (any request set).
module rr_pick #(
    parameter int N_SRC = 8,
    parameter int SEL_W = 3
) (
    input  logic [N_SRC-1:0] i_req,
    input  logic [SEL_W-1:0] i_ptr,
    output logic [SEL_W-1:0] o_idx,
    output logic             o_any
);

    // Walk the search order backwards so the last hit written is the
    // nearest one after the pointer.
    always_comb begin
        int j;
        o_idx = '0;
        o_any = |i_req;
        for (int i = N_SRC; i >= 1; i--) begin
            j = (int'(i_ptr) + i) % N_SRC;
            if (i_req[j]) o_idx = SEL_W'(j);
        end
    end

endmodule

// File: rtl/vga_draw_arbiter.sv
// rtl/vga_draw_arbiter.sv - merges N_SRC drawing engines onto one vga_adapter port
//
// Purpose: forced (game FSM select) or round-robin arbitrated ownership of
//          the x/y/colour/plot port, with a blanking gap on owner changes
//          and optional burst preemption.
// Ports:   clk, reset_n (async active-low);
//          bus (slave modport): mode, sel_in, src_req/x/y/color/plot in;
//          src_grant, x_out, y_out, color_out, plot_out, owner,
//          owner_valid, switch_pulse out.
module vga_draw_arbiter
    import vga_draw_pkg::*;
#(
    parameter int N_SRC     = 8,
    parameter int X_W       = 9,
    parameter int Y_W       = 8,
    parameter int C_W       = 3,
    parameter int MAX_BURST = 0
) (
    input  logic               clk,
    input  logic               reset_n,
    vga_draw_arbiter_if.slave  bus
);

    localparam int SEL_W = clog2(N_SRC);
    localparam int BW    = clog2(MAX_BURST + 2);
    localparam logic [BW-1:0] BURST_LAST = (MAX_BURST == 0) ? '0 : BW'(MAX_BURST - 1);

    state_t           r_state;
    logic [SEL_W-1:0] r_owner;
    logic [SEL_W-1:0] r_ptr;
    logic [BW-1:0]    r_burst;
    logic             r_own_mode;
    logic [X_W-1:0]   r_x;
    logic [Y_W-1:0]   r_y;
    logic [C_W-1:0]   r_c;
    logic             r_plot;
    logic [N_SRC-1:0] r_grant;
    logic             r_switch;

    state_t           w_next_state;
    logic [SEL_W-1:0] w_next_owner;
    logic [SEL_W-1:0] w_next_ptr;
    logic [BW-1:0]    w_next_burst;
    logic [SEL_W-1:0] w_pick;
    logic             w_any_req;
    logic             w_tgt_valid;
    logic [N_SRC-1:0] w_owner_oh;
    logic             w_others;
    logic             w_preempt;
    logic             w_enter_owned;

    rr_pick #(.N_SRC(N_SRC), .SEL_W(SEL_W)) u_rr_pick (
        .i_req (bus.src_req),
        .i_ptr (r_ptr),
        .o_idx (w_pick),
        .o_any (w_any_req)
    );

    assign w_tgt_valid   = int'(bus.sel_in) < N_SRC;
    assign w_owner_oh    = N_SRC'(1) << r_owner;
    assign w_others      = |(bus.src_req & ~w_owner_oh);
    assign w_preempt     = (MAX_BURST != 0) && (r_burst == BURST_LAST) && w_others;
    assign w_enter_owned = (w_next_state == OWNED) && (r_state != OWNED);

    always_comb begin
        w_next_state = r_state;
        w_next_owner = r_owner;
        w_next_ptr   = r_ptr;
        w_next_burst = r_burst;
        case (r_state)
            IDLE, GAP: begin
                if (bus.mode == MODE_ARB) begin
                    if (w_any_req) begin
                        w_next_state = OWNED;
                        w_next_owner = w_pick;
                        w_next_ptr   = w_pick;
                    end else begin
                        w_next_state = IDLE;
                    end
                end else if (!w_tgt_valid) begin
                    w_next_state = IDLE;
                end else if (r_state == GAP) begin
                    w_next_state = OWNED;
                    w_next_owner = bus.sel_in;
                end else begin
                    // Forced hand-over always blanks one cycle, even from IDLE.
                    w_next_state = GAP;
                end
            end
            OWNED: begin
                if (bus.mode != r_own_mode) begin
                    w_next_state = GAP;
                end else if (bus.mode == MODE_FORCED) begin
                    if (!w_tgt_valid)                w_next_state = IDLE;
                    else if (bus.sel_in != r_owner)  w_next_state = GAP;
                end else if (!bus.src_req[r_owner] || w_preempt) begin
                    w_next_state = GAP;
                end else if (r_burst != '1) begin
                    w_next_burst = r_burst + 1'b1;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_owner    <= '0;
            r_ptr      <= SEL_W'(N_SRC - 1);
            r_burst    <= '0;
            r_own_mode <= 1'b0;
            r_x        <= '0;
            r_y        <= '0;
            r_c        <= '0;
            r_plot     <= 1'b0;
            r_grant    <= '0;
            r_switch   <= 1'b0;
        end else begin
            r_state  <= w_next_state;
            r_owner  <= w_next_owner;
            r_ptr    <= w_next_ptr;
            r_burst  <= w_enter_owned ? '0 : w_next_burst;
            r_switch <= w_enter_owned;
            r_grant  <= (w_next_state == OWNED) ? (N_SRC'(1) << w_next_owner) : '0;
            if (w_enter_owned) r_own_mode <= bus.mode;
            if (r_state == OWNED) begin
                r_x    <= bus.src_x[r_owner*X_W +: X_W];
                r_y    <= bus.src_y[r_owner*Y_W +: Y_W];
                r_c    <= bus.src_color[r_owner*C_W +: C_W];
                // Suppress the last pixel of an owner that is about to lose the port.
                r_plot <= bus.src_plot[r_owner] && (w_next_state == OWNED) &&
                          (w_next_owner == r_owner);
            end else begin
                r_plot <= 1'b0;
            end
        end
    end

    assign bus.src_grant    = r_grant;
    assign bus.x_out        = r_x;
    assign bus.y_out        = r_y;
    assign bus.color_out    = r_c;
    assign bus.plot_out     = r_plot;
    assign bus.owner        = r_owner;
    assign bus.owner_valid  = (r_state == OWNED);
    assign bus.switch_pulse = r_switch;

endmodule

// File: doc/vga_draw_arbiter.md
Name: vga_draw_arbiter

Overview:
- Parametrised successor to the top-level draw-source mux. It merges N_SRC drawing engines (start, jump, saved, death, black screen, win, game over, plus spares) onto the single x/y/colour/plot port of vga_adapter.
- Two modes:
  - Forced: the game FSM selects the source, as today.
  - Arbitrated: round-robin with a req/grant handshake and optional burst preemption.
- A one-cycle plot blanking gap on every owner change prevents stray pixels.

Parameters:
- N_SRC, 8, number of draw sources (2..16).
- X_W, 9, x coordinate width.
- Y_W, 8, y coordinate width.
- C_W, 3, colour width.
- MAX_BURST, 0, maximum consecutive OWNED cycles before preemption when other requests are pending; 0 means unlimited.
- SEL_W, derived localparam, equal to clog2(N_SRC).

Ports:
- clk  in  1  system clock (CLOCK_50 domain).
- reset_n  in  1  asynchronous active-low reset.
- mode  in  1  0 = forced select, 1 = arbitrated.
- sel_in  in  SEL_W  forced-mode source index.
- src_req  in  N_SRC  per-source draw request (arbitrated mode).
- src_x  in  N_SRC*X_W  packed x; source i occupies [i*X_W +: X_W].
- src_y  in  N_SRC*Y_W  packed y.
- src_color  in  N_SRC*C_W  packed colour.
- src_plot  in  N_SRC  per-source plot strobe.
- src_grant  out  N_SRC  one-hot grant, registered.
- x_out  out  X_W  to vga_adapter x.
- y_out  out  Y_W  to vga_adapter y.
- color_out  out  C_W  to vga_adapter colour.
- plot_out  out  1  to vga_adapter plot.
- owner  out  SEL_W  current owner index.
- owner_valid  out  1  high while in OWNED.
- switch_pulse  out  1  one-cycle pulse on the cycle OWNED is entered.

Behaviour:

Reset (asynchronous, reset_n low):
- All outputs are 0.
- State is IDLE.
- The round-robin pointer is N_SRC-1, so the first pick is source 0.
- The burst counter is 0.
- Reset mid-burst drops plot_out immediately (asynchronous).

States: IDLE, OWNED, GAP. Transitions are evaluated on each rising clk edge.

Output datapath:
- Registered, with 1-cycle latency.
- On each edge, x_out, y_out and color_out capture the slices of source `owner`.
- plot_out captures src_plot[owner] AND (next state == OWNED AND next owner == owner).
- In IDLE and GAP, plot_out is 0 and x_out, y_out and color_out hold their values.
- src_grant equals onehot(owner) while in OWNED, else 0.

Arbitrated mode (mode = 1):
- IDLE: if any src_req is high, owner becomes rr_pick and state goes to OWNED. rr_pick is the first set bit searching upward from pointer+1 with wrap-around. The pointer is set to the picked index.
- OWNED, owner's src_req low: go to GAP. Grant falls at the same edge.
- OWNED, preemption: if MAX_BURST != 0, the burst counter equals MAX_BURST-1, and any other req is high, go to GAP (preempted). Otherwise the burst counter increments and saturates.
- GAP, exactly one cycle: if any req is high, do rr_pick and go to OWNED; else go to IDLE.
- Because the pointer advances past the previous owner, a preempted source re-wins only when no other source requests.
- Simultaneous requests resolve strictly by round-robin order.
- The burst counter clears on entry to OWNED.

Forced mode (mode = 0):
- src_req is ignored.
- Target is sel_in when sel_in < N_SRC; otherwise there is no target and the block goes or stays in IDLE. This covers the illegal index, which was unhandled previously.
- If the target differs from owner, or the state is IDLE with a valid target, go to GAP, then OWNED with owner = target at the following edge.
- While the target equals owner, stay in OWNED indefinitely. MAX_BURST is not applied.

Mode change while OWNED: always go to GAP, then re-evaluate under the new mode.

switch_pulse: high for the first OWNED cycle after every IDLE→OWNED or GAP→OWNED transition.

Decomposition:
- Package vga_draw_pkg:
  - state encoding localparams (IDLE=2'd0, OWNED=2'd1, GAP=2'd2);
  - a clog2 constant function;
  - mode encoding constants.
- Sub-module rr_pick (combinational): inputs are the req vector and pointer; outputs are the index and any_req. It is instantiated once.

Test Plan:
- Reset scenario: reset_n low mid-stream with src_plot[0] = 1 → plot_out = 0 and src_grant = 0 immediately. After release with no req, the block stays in IDLE.
- Forced-select timing: mode = 0, sel_in = 2, src_x[2] = 9'd100, src_plot[2] = 1 → GAP for one cycle, then OWNED. switch_pulse fires once, and x_out = 100 with plot_out = 1 one cycle after OWNED is entered. Then change sel_in to 5 → exactly one cycle of plot_out = 0 before source 5 data appears.
- Illegal index: mode = 0, N_SRC = 6, sel_in = 7 → owner_valid = 0, plot_out = 0, src_grant = 0.
- Round-robin: mode = 1, src_req = 8'b0000_1011 held, each owner drops req after 4 cycles then re-raises → grant order is 0, 1, 3, 0, … with one GAP cycle between owners.
- Preemption: MAX_BURST = 3, src_req[4] held high, src_req[6] raised at cycle 1 → source 4 gets 3 OWNED cycles, then GAP, then source 6. With source 6 absent, source 4 keeps OWNED beyond 3 cycles.
- Mode switch mid-burst: mode toggled 1→0 while source 3 is OWNED and sel_in = 1 → GAP, then owner = 1. No cycle ever shows plot_out = 1 carrying data from a non-owner.
